// File: rtl/srm_pkg.sv
// Shared encodings for the SRM instruction controller: states, opcode/op
// classes, register-select and writeback-source codes, control word layout.
package srm_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned NSEL_W  = 3;
  localparam int unsigned VSEL_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_ALU_OP = 3'd5,
    S_CMP_OP = 3'd6,
    S_WR_RD  = 3'd7
  } state_e;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
  localparam logic [OP_W-1:0] OP_AND     = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN     = 2'b11;
  localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
  localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;

  localparam logic [NSEL_W-1:0] NSEL_RN = 3'b100;
  localparam logic [NSEL_W-1:0] NSEL_RD = 3'b010;
  localparam logic [NSEL_W-1:0] NSEL_RM = 3'b001;

  localparam logic [VSEL_W-1:0] VSEL_C     = 2'b00;
  localparam logic [VSEL_W-1:0] VSEL_PC    = 2'b01;
  localparam logic [VSEL_W-1:0] VSEL_IMM   = 2'b10;
  localparam logic [VSEL_W-1:0] VSEL_MDATA = 2'b11;

  typedef struct packed {
    logic              w;
    logic [NSEL_W-1:0] nsel;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic [VSEL_W-1:0] vsel;
    logic              write;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{w: 1'b1, nsel: NSEL_RM, loada: 1'b0, loadb: 1'b0,
                                  loadc: 1'b0, loads: 1'b0, asel: 1'b0, bsel: 1'b0,
                                  vsel: VSEL_C, write: 1'b0};

  // MOV-reg and MVN pass only the B operand through the ALU, so A is forced to zero.
  function automatic logic a_is_zero(input logic [OPC_W-1:0] opcode, input logic [OP_W-1:0] op);
    return ((opcode == OPC_MOV) && (op == OP_MOV_REG)) ||
           ((opcode == OPC_ALU) && (op == OP_MVN));
  endfunction

endpackage

// File: rtl/srm_ctrl_outdec.sv
// Control-word decode for one controller state; opcode/op only shape the
// A-operand select inside ALU_OP.
module srm_ctrl_outdec
  import srm_pkg::*;
(
  input  state_e           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic [OP_W-1:0]  op,
  output ctrl_t            ctrl_c
);

  always_comb begin
    ctrl_c   = CTRL_IDLE;
    ctrl_c.w = 1'b0;
    case (state)
      S_WAIT:   ctrl_c.w = 1'b1;
      S_DECODE: ctrl_c.w = 1'b0;
      S_WR_IMM: begin
        ctrl_c.nsel  = NSEL_RN;
        ctrl_c.vsel  = VSEL_IMM;
        ctrl_c.write = 1'b1;
      end
      S_GET_A: begin
        ctrl_c.nsel  = NSEL_RN;
        ctrl_c.loada = 1'b1;
      end
      S_GET_B: begin
        ctrl_c.nsel  = NSEL_RM;
        ctrl_c.loadb = 1'b1;
      end
      S_ALU_OP: begin
        ctrl_c.loadc = 1'b1;
        ctrl_c.asel  = a_is_zero(opcode, op);
      end
      S_CMP_OP: ctrl_c.loads = 1'b1;
      S_WR_RD: begin
        ctrl_c.nsel  = NSEL_RD;
        ctrl_c.vsel  = VSEL_C;
        ctrl_c.write = 1'b1;
      end
      default: ctrl_c = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/srm_fsm_ctrl.sv
// SRM instruction sequencer: steps the datapath through each instruction class.
// Outputs are registered from the next-state decode so they always match the state register.
module srm_fsm_ctrl
  import srm_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [OP_W-1:0]   op,
  output logic              w,
  output logic [NSEL_W-1:0] nsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [VSEL_W-1:0] vsel,
  output logic              write
);

  state_e state_q, state_d;
  ctrl_t  ctrl_d, ctrl_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   state_d = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if ((opcode == OPC_MOV) && (op == OP_MOV_IMM))      state_d = S_WR_IMM;
        else if ((opcode == OPC_MOV) && (op == OP_MOV_REG)) state_d = S_GET_B;
        else if (opcode == OPC_ALU)                         state_d = (op == OP_MVN) ? S_GET_B : S_GET_A;
        else                                                state_d = S_WAIT;
      end
      S_WR_IMM: state_d = S_WAIT;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = ((opcode == OPC_ALU) && (op == OP_CMP)) ? S_CMP_OP : S_ALU_OP;
      S_ALU_OP: state_d = S_WR_RD;
      S_CMP_OP: state_d = S_WAIT;
      S_WR_RD:  state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  srm_ctrl_outdec u_outdec (
    .state  (state_d),
    .opcode (opcode),
    .op     (op),
    .ctrl_c (ctrl_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign w     = ctrl_q.w;
  assign nsel  = ctrl_q.nsel;
  assign loada = ctrl_q.loada;
  assign loadb = ctrl_q.loadb;
  assign loadc = ctrl_q.loadc;
  assign loads = ctrl_q.loads;
  assign asel  = ctrl_q.asel;
  assign bsel  = ctrl_q.bsel;
  assign vsel  = ctrl_q.vsel;
  assign write = ctrl_q.write;

endmodule

// File: tb/tb_srm_fsm_ctrl.sv
// Self-checking bench for srm_fsm_ctrl: directed instruction classes, reset,
// back-to-back starts and random instructions against a per-instruction output script.
module tb_srm_fsm_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0] nsel;
  logic [1:0] vsel;

  int n_total = 0;
  int n_pass  = 0;

  logic [12:0] exp_q[$];

  srm_fsm_ctrl dut (
    .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic ww, input logic [2:0] ns, input logic la,
                                     input logic lb, input logic lc, input logic ls,
                                     input logic as, input logic bs, input logic [1:0] vs,
                                     input logic wr);
    return {ww, ns, la, lb, lc, ls, as, bs, vs, wr};
  endfunction

  function automatic logic [12:0] obs();
    return {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write};
  endfunction

  localparam logic [12:0] IDLE = 13'b1_001_000000_00_0;
  localparam logic [12:0] DEC  = 13'b0_001_000000_00_0;

  task automatic check(input string tag, input logic [12:0] o, input logic [12:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  // Invariants: one-hot register select; writes only with the two legal select/source pairs.
  task automatic check_inv(input string tag);
    logic wr_ok;
    wr_ok = !write || (nsel == 3'b100 && vsel == 2'b10) || (nsel == 3'b010 && vsel == 2'b00);
    check({tag, "_onehot"}, 13'($onehot(nsel)), 13'd1);
    check({tag, "_wrlegal"}, 13'(wr_ok), 13'd1);
  endtask

  // Reference script: the control word seen on each busy cycle of one instruction.
  task automatic build(input logic [2:0] opc, input logic [1:0] o);
    bit movi, movr, is_alu, cmp, mvn, legal;
    movi   = (opc == 3'b110) && (o == 2'b10);
    movr   = (opc == 3'b110) && (o == 2'b00);
    is_alu = (opc == 3'b101);
    cmp    = is_alu && (o == 2'b01);
    mvn    = is_alu && (o == 2'b11);
    legal  = movi || movr || is_alu;
    exp_q.delete();
    exp_q.push_back(DEC);
    if (movi) exp_q.push_back(mk(0, 3'b100, 0, 0, 0, 0, 0, 0, 2'b10, 1));
    if (is_alu && !mvn) exp_q.push_back(mk(0, 3'b100, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    if (legal && !movi) begin
      exp_q.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      if (cmp) exp_q.push_back(mk(0, 3'b001, 0, 0, 0, 1, 0, 0, 2'b00, 0));
      else begin
        exp_q.push_back(mk(0, 3'b001, 0, 0, 1, 0, logic'(movr || mvn), 0, 2'b00, 0));
        exp_q.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 1));
      end
    end
  endtask

  function automatic int latency(input logic [2:0] opc, input logic [1:0] o);
    if (opc == 3'b110 && o == 2'b10) return 2;
    if (opc == 3'b110 && o == 2'b00) return 4;
    if (opc == 3'b101) return (o == 2'b00 || o == 2'b10) ? 5 : 4;
    return 1;
  endfunction

  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input string tag);
    int busy;
    busy = 0;
    build(opc, o);
    @(negedge clk);
    check({tag, "_pre"}, obs(), IDLE);
    s = 1'b1; opcode = opc; op = o;
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i), obs(), exp_q[i]);
      check_inv(tag);
      if (!w) busy++;
      s = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check({tag, "_end"}, obs(), IDLE);
    s = 1'b0;
    check({tag, "_lat"}, 13'(busy), 13'(latency(opc, o)));
  endtask

  initial begin
    logic [12:0] wrimm;
    int r, pulses;
    logic [2:0] ropc;
    logic [1:0] rop;
    wrimm   = mk(0, 3'b100, 0, 0, 0, 0, 0, 0, 2'b10, 1);
    reset_n = 1'b0; s = 1'b0; opcode = 3'b000; op = 2'b00;

    @(negedge clk);
    check("reset_state", obs(), IDLE);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", obs(), IDLE);

    run_instr(3'b101, 2'b00, "add");
    run_instr(3'b101, 2'b10, "and");
    run_instr(3'b101, 2'b01, "cmp");
    run_instr(3'b101, 2'b11, "mvn");
    run_instr(3'b110, 2'b00, "movr");
    run_instr(3'b110, 2'b10, "movi");
    run_instr(3'b111, 2'b00, "ill111");
    run_instr(3'b110, 2'b01, "ill110_01");

    // s held high: two MOV-imm instructions separated by one WAIT cycle
    @(negedge clk);
    s = 1'b1; opcode = 3'b110; op = 2'b10;
    pulses = 0;
    @(negedge clk); check("b2b_dec0", obs(), DEC);
    @(negedge clk); check("b2b_wr0", obs(), wrimm); pulses += int'(write);
    @(negedge clk); check("b2b_wait", obs(), IDLE);
    @(negedge clk); check("b2b_dec1", obs(), DEC);
    @(negedge clk); check("b2b_wr1", obs(), wrimm); pulses += int'(write);
    s = 1'b0;
    @(negedge clk); check("b2b_end", obs(), IDLE);
    check("b2b_pulses", 13'(pulses), 13'd2);

    for (int k = 0; k < 30; k++) begin
      r    = int'($urandom_range(0, 3));
      ropc = (r < 2) ? 3'b101 : (r == 2) ? 3'b110 : 3'($urandom_range(0, 7));
      rop  = 2'($urandom_range(0, 3));
      run_instr(ropc, rop, $sformatf("rnd%0d", k));
    end

    // Reset asserted while an ADD sits in GET_B
    build(3'b101, 2'b00);
    @(negedge clk);
    s = 1'b1; opcode = 3'b101; op = 2'b00;
    @(negedge clk); check("rst_add_dec", obs(), exp_q[0]);
    @(negedge clk); check("rst_add_geta", obs(), exp_q[1]);
    @(negedge clk); check("rst_add_getb", obs(), exp_q[2]);
    reset_n = 1'b0;
    #1 check("rst_async", obs(), IDLE);
    @(negedge clk); check("rst_hold", obs(), IDLE);
    reset_n = 1'b1; s = 1'b0;
    @(negedge clk); check("rst_release", obs(), IDLE);
    s = 1'b1; opcode = 3'b110; op = 2'b10;
    @(negedge clk); check("rst_first_dec", obs(), DEC);
    s = 1'b0;
    @(negedge clk); check("rst_first_wr", obs(), wrimm);
    @(negedge clk); check("rst_first_end", obs(), IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/srm_fsm_ctrl.md
SRM_FSM_CTRL -- requirements
Module: srm_fsm_ctrl

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-003 s  in  1  start pulse/level; sampled only in WAIT.
REQ-004 opcode  in  3  instruction class from decoder (IR[15:13]).
REQ-005 op  in  2  sub-op from decoder (IR[12:11]).
REQ-006 w  out  1  1 = idle, IR may be reloaded.
REQ-007 nsel  out  3  one-hot register select to decoder: 100=Rn, 010=Rd, 001=Rm.
REQ-008 loada, loadb, loadc, loads  out  1 each  datapath register enables.
REQ-009 asel, bsel  out  1 each  ALU operand selects; asel=1 forces A=0, bsel=1 selects sximm5.
REQ-010 vsel  out  2  writeback source: 00=C, 01=PC, 10=sximm8, 11=mdata.
REQ-011 write  out  1  register-file write enable.

Function
REQ-012 Moore FSM; all outputs SHALL be decoded from the current state only.
REQ-013 States: WAIT, DECODE, WR_IMM, GET_A, GET_B, ALU_OP, CMP_OP, WR_RD.
REQ-014 WAIT: w=1; next state DECODE if s=1, else WAIT.
REQ-015 DECODE SHALL sample opcode/op and branch: 110/10 -> WR_IMM; 110/00 -> GET_B; 101/00, 101/01, 101/10 -> GET_A; 101/11 -> GET_B; any other code -> WAIT (no write, no load).
REQ-016 WR_IMM: nsel=100, vsel=10, write=1; next WAIT.
REQ-017 GET_A: nsel=100, loada=1; next GET_B.
REQ-018 GET_B: nsel=001, loadb=1; next CMP_OP if op=01 and opcode=101, else ALU_OP.
REQ-019 ALU_OP: loadc=1, bsel=0; asel=1 for MOV-reg (110/00) and MVN (101/11), asel=0 for ADD/AND; next WR_RD.
REQ-020 CMP_OP: asel=0, bsel=0, loads=1, loadc=0; next WAIT.
REQ-021 WR_RD: nsel=010, vsel=00, write=1; next WAIT.
REQ-022 Default outputs in every state not listed above: loads/write/asel/bsel=0, vsel=00, nsel=001 (nsel SHALL never be 000 or multi-hot).
REQ-023 Latency, cycles spent outside WAIT: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5, illegal 1.
REQ-024 w SHALL be 0 in every non-WAIT state; s SHALL be ignored outside WAIT.
REQ-025 opcode/op SHALL be re-evaluated in GET_B and ALU_OP; upstream holds IR stable while w=0.
REQ-026 s held high continuously SHALL start a new instruction on the cycle after return to WAIT (back-to-back, one WAIT cycle between instructions).

Reset
REQ-027 reset_n=0 SHALL force WAIT asynchronously from any state, including mid-instruction.
REQ-028 Reset output values: w=1, nsel=001, all loads/write/asel/bsel=0, vsel=00.
REQ-029 No partial write SHALL complete after reset assertion; first post-reset edge with s=1 enters DECODE.

Structure
REQ-030 Shared package srm_pkg SHALL hold state encoding, opcode/op constants (MOV=110, ALU=101, ADD/CMP/AND/MVN=00/01/10/11), nsel constants and vsel constants.
REQ-031 State register and next-state logic SHALL reside in srm_fsm_ctrl; output decode SHALL be one sub-module srm_ctrl_outdec (state, opcode, op -> outputs).
REQ-032 Estimated size 150-250 lines RTL; no latches; all case statements fully specified.

Verification
REQ-033 Reset mid-GET_B (ADD in flight) -> next sample shows WAIT, w=1, nsel=001, loadb=0, write=0.
REQ-034 opcode=110, op=10, s=1 one cycle -> DECODE, then WR_IMM with nsel=100, vsel=10, write=1, then w=1; total 2 cycles with w=0.
REQ-035 opcode=101, op=00 (ADD) -> GET_A(nsel=100, loada), GET_B(nsel=001, loadb), ALU_OP(asel=0, loadc), WR_RD(nsel=010, write); 5 cycles with w=0.
REQ-036 opcode=101, op=01 (CMP) -> ends in CMP_OP with loads=1 and write never asserted; opcode=101, op=11 (MVN) -> skips GET_A, asel=1 in ALU_OP.
REQ-037 opcode=111 or 110/01, s=1 -> DECODE then WAIT, no load/write asserted; s held high across two MOV imm -> two WR_IMM pulses separated by WAIT+DECODE.
REQ-038 Assertion over all runs: nsel one-hot at every cycle; write=1 only in WR_IMM/WR_RD.
